// File: rtl/frame_ola.sv
`default_nettype none
// ============================================================================
//  Module   : frame_ola
//  Purpose  : Overlap-add reassembler; sums windowed frames at HOP spacing and
//             serializes the reconstructed stream one sample per sample tick.
//  Revision : 1.0 - initial release
// ============================================================================
module frame_ola #(
    parameter int DATA_W    = 12,
    parameter int FRAME_LEN = 128,
    parameter int HOP       = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_frame [0:FRAME_LEN-1],
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sample_tick,
    output logic [DATA_W-1:0] out_sample,
    output logic              out_valid,
    output logic              overflow,
    output logic              underrun
);

    localparam int                   c_acc_w  = DATA_W + 1;
    localparam int                   c_pend_w = $clog2(HOP + 1);
    localparam logic [c_pend_w-1:0]  c_hop    = c_pend_w'(HOP);
    localparam logic [DATA_W-1:0]    c_max    = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]    c_min    = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [0:0]           c_s_idle = 1'b0;
    localparam logic [0:0]           c_s_run  = 1'b1;

    logic [c_acc_w-1:0]  r_acc [0:FRAME_LEN-1];
    logic [c_pend_w-1:0] r_pend;
    logic [0:0]          r_state;
    logic [DATA_W-1:0]   r_out_sample;
    logic                r_out_valid;
    logic                r_overflow;
    logic                r_underrun;

    logic                w_ready;
    logic                w_accept;
    logic                w_shift;
    logic [c_acc_w-1:0]  w_head;
    logic [DATA_W-1:0]   w_head_sat;

    assign w_ready  = (r_pend == '0);
    assign w_accept = in_valid && w_ready;
    // A tick can only coincide with an accept when nothing is pending, so
    // shifting and accumulating never happen on the same edge.
    assign w_shift  = sample_tick && !w_ready;

    // Two overlapping frames can exceed the output range; clamp on the way out.
    always_comb begin
        w_head     = r_acc[0];
        w_head_sat = w_head[DATA_W-1:0];
        if (w_head[DATA_W] != w_head[DATA_W-1])
            w_head_sat = w_head[DATA_W] ? c_min : c_max;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FRAME_LEN; i++)
                r_acc[i] <= '0;
            r_pend       <= '0;
            r_state      <= c_s_idle;
            r_out_sample <= '0;
            r_out_valid  <= 1'b0;
            r_overflow   <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_out_valid <= w_shift;
            r_overflow  <= in_valid && !w_ready;
            r_underrun  <= sample_tick && w_ready && (r_state == c_s_run) && !w_accept;
            if (w_accept) begin
                for (int i = 0; i < FRAME_LEN; i++)
                    r_acc[i] <= r_acc[i] + {in_frame[i][DATA_W-1], in_frame[i]};
                r_pend  <= c_hop;
                r_state <= c_s_run;
            end else if (w_shift) begin
                r_out_sample <= w_head_sat;
                for (int i = 0; i < FRAME_LEN - 1; i++)
                    r_acc[i] <= r_acc[i+1];
                r_acc[FRAME_LEN-1] <= '0;
                r_pend <= r_pend - c_pend_w'(1);
            end
        end
    end

    assign in_ready   = w_ready;
    assign out_sample = r_out_sample;
    assign out_valid  = r_out_valid;
    assign overflow   = r_overflow;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_frame_ola.sv
`default_nettype none
// ============================================================================
//  Module   : tb_frame_ola
//  Purpose  : Directed self-checking bench for frame_ola.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_frame_ola;

    localparam int DATA_W    = 12;
    localparam int FRAME_LEN = 128;
    localparam int HOP       = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] in_frame [0:FRAME_LEN-1];
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              sample_tick = 1'b0;
    logic [DATA_W-1:0] out_sample;
    logic              out_valid;
    logic              overflow;
    logic              underrun;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    frame_ola #(
        .DATA_W   (DATA_W),
        .FRAME_LEN(FRAME_LEN),
        .HOP      (HOP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_frame   (in_frame),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sample_tick(sample_tick),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .overflow   (overflow),
        .underrun   (underrun)
    );

    function automatic logic [31:0] s12(input int v);
        logic [DATA_W-1:0] t;
        t = DATA_W'(v);
        return 32'(t);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic load(input int base, input int stp);
        for (int i = 0; i < FRAME_LEN; i++)
            in_frame[i] = DATA_W'(base + stp * i);
    endtask

    // Called at a negedge; inputs change here, outputs are sampled at the next negedge.
    task automatic send();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("accept_ready_low", 32'(in_ready), 32'd0);
        chk("accept_no_ovf", 32'(overflow), 32'd0);
    endtask

    task automatic tick();
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic drain(input string tag, input int n, input int base, input int stp);
        for (int k = 0; k < n; k++) begin
            tick();
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_sample"}, 32'(out_sample), s12(base + stp * k));
            chk({tag, "_no_underrun"}, 32'(underrun), 32'd0);
        end
    endtask

    // The frame offered during reset must be ignored.
    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sample", 32'(out_sample), 32'd0);
    endtask

    initial begin
        load(0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_ready", 32'(in_ready), 32'd1);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_sample", 32'(out_sample), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_underrun", 32'(underrun), 32'd0);

        // Ticks while idle never report underrun.
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_no_underrun", 32'(underrun), 32'd0);
            chk("idle_no_valid", 32'(out_valid), 32'd0);
        end

        // Single frame, then overlapping second frame.
        load(100, 0);
        send();
        drain("f1", 64, 100, 0);
        chk("f1_ready_after", 32'(in_ready), 32'd1);
        send();
        drain("f2", 64, 200, 0);

        // Positive and negative saturation.
        do_reset();
        load(1500, 0);
        send();
        drain("pos1", 64, 1500, 0);
        send();
        drain("pos_sat", 64, 2047, 0);
        do_reset();
        load(-1500, 0);
        send();
        drain("neg1", 64, -1500, 0);
        send();
        drain("neg_sat", 64, -2048, 0);

        // Ramp ordering.
        do_reset();
        load(0, 1);
        send();
        drain("ramp", 64, 0, 1);

        // Frame offered while draining is dropped with an overflow pulse.
        do_reset();
        load(5, 0);
        send();
        drain("ovf_pre", 34, 5, 0);
        load(999, 0);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ovf_pulse", 32'(overflow), 32'd1);
        chk("ovf_ready_low", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("ovf_one_cycle", 32'(overflow), 32'd0);
        chk("ovf_no_valid", 32'(out_valid), 32'd0);
        drain("ovf_post", 29, 5, 0);
        chk("ovf_ready_still_low", 32'(in_ready), 32'd0);
        drain("ovf_last", 1, 5, 0);
        chk("ovf_ready_back", 32'(in_ready), 32'd1);

        // 65th tick: underrun, no output, sample holds.
        tick();
        chk("urun_pulse", 32'(underrun), 32'd1);
        chk("urun_no_valid", 32'(out_valid), 32'd0);
        chk("urun_hold", 32'(out_sample), s12(5));
        @(negedge clk);
        chk("urun_one_cycle", 32'(underrun), 32'd0);

        // Mid-stream reset discards pending samples.
        do_reset();
        load(9, 0);
        send();
        drain("pre_rst", 10, 9, 0);
        load(7, 0);
        do_reset();
        send();
        drain("post_rst", 64, 7, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_ola.md
Name: frame_ola

Overview:
- Overlap-add frame reassembler: the reader side of the windowed-frame interface produced by the hamming stage.
- Accepts parallel FRAME_LEN-sample windowed frames, sums them with HOP-sample overlap, and serializes the reconstructed stream one sample per 8 kHz sample tick.
- Used for audio loopback/debug output (DAC path) and for checking the framing chain end to end.

Parameters:
- DATA_W, 12, sample width; signed two's complement in and out.
- FRAME_LEN, 128, samples per input frame.
- HOP, 64, new samples per frame (overlap = FRAME_LEN-HOP); must satisfy 1 <= HOP <= FRAME_LEN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_frame  in  DATA_W x FRAME_LEN (unpacked array [0:FRAME_LEN-1])  windowed frame; element 0 is oldest
- in_valid  in  1  frame present; sampled every cycle
- in_ready  out  1  frame can be accepted this cycle
- sample_tick  in  1  one-cycle strobe at output sample rate
- out_sample  out  DATA_W  reconstructed sample, registered
- out_valid  out  1  one-cycle pulse, out_sample new
- overflow  out  1  one-cycle pulse, frame offered while not ready (frame dropped)
- underrun  out  1  one-cycle pulse, tick with no sample available

Behaviour:
- Storage: acc[0..FRAME_LEN-1], each DATA_W+1 bits signed; pend counter, $clog2(HOP+1) bits; state in {IDLE, RUN}.
- Reset state:
  - acc all 0, pend=0, state=IDLE.
  - out_sample=0, out_valid=0, overflow=0, underrun=0, in_ready=1.
- in_ready = (pend==0), combinational from registered state.
- Accept (in_valid && in_ready):
  - Next edge: acc[i] <= acc[i] + sext(in_frame[i]) for all i.
  - Next edge: pend <= HOP, state <= RUN.
- Reject (in_valid && !in_ready):
  - Frame ignored, acc/pend unchanged.
  - overflow=1 on the next cycle for one cycle.
- Tick with pend>0:
  - Next edge: out_sample <= sat(acc[0]), out_valid=1 for one cycle.
  - Next edge: acc[i] <= acc[i+1] for i<FRAME_LEN-1, acc[FRAME_LEN-1] <= 0, pend <= pend-1.
- Tick with pend==0:
  - No shift, out_valid=0, out_sample holds.
  - underrun=1 next cycle only if state==RUN and no accept this cycle.
  - Never flagged in IDLE.
- Tick and accept in the same cycle are only possible with pend==0. Accept wins; no output, no underrun; the tick is consumed.
- Saturation: sat() clamps the (DATA_W+1)-bit value to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. acc itself never wraps: at most two overlapping frames contribute when HOP >= FRAME_LEN/2.
- Latency: frame accepted in cycle N; earliest out_valid is cycle T+1 for the first tick T >= N+1.
- Stream semantics: first HOP outputs after frame k equal frame k's elements 0..HOP-1 plus the tail of frame k-1.
- out_sample holds its last value between pulses.
- Reset mid-operation: all state cleared in one cycle, pending samples discarded, returns to IDLE.
- Any in_valid in the reset cycle is ignored.

Test Plan:
- Reset, then one frame of all +100, 64 ticks -> 64 out_valid pulses each out_sample=100; in_ready returns to 1 after the 64th tick; no underrun.
- Second frame of all +100 after draining, 64 ticks -> outputs 200 (overlap of frame1[64..127] + frame2[0..63]).
- Two consecutive frames of +1500 -> second hop outputs clamp to 2047. With -1500 frames -> -2048. Ramp frame in[i]=i -> first hop outputs 0..63 in order.
- in_valid asserted during draining (pend=30) -> overflow pulse 1 cycle; subsequent outputs unchanged; in_ready stays 0 until pend=0.
- 65 ticks after one frame -> 64 valid outputs, then an underrun pulse on the 65th tick with no out_valid. Ticks before any frame (IDLE) -> no underrun.
- rst asserted after 10 outputs -> next cycle in_ready=1, out_valid=0. New frame of +7 -> outputs 7 (no residue from the prior frame).
